score_bcd_display: RTL and testbench

SCORE_BCD_DISPLAY -- requirements
Module: score_bcd_display

---
 rtl/score_bcd_display.sv | 183 ++++++++++++++++++
 tb/tb_score_bcd_display.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - iterative double-dabble score converter driving active-low 7-segment digits
module score_bcd_display #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic                blank_q, blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0]    pend_value_q, pend_value_d;
    logic                pend_blank_q, pend_blank_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic [BW-1:0]       bcd_adj;
    logic [3:0]          adj_nib;
    logic [7*DIGITS-1:0] hex_new;
    logic [3:0]          dec_nib;
    logic                dec_seen;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // add-3 correction applied to every nibble before the shift
    always_comb begin
        bcd_adj = '0;
        adj_nib = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj_nib = bcd_q[4*k +: 4];
            bcd_adj[4*k +: 4] = (adj_nib >= 4'd5) ? adj_nib + 4'd3 : adj_nib;
        end
    end

    // walk from the top digit down so blanking stops at the first nonzero digit
    always_comb begin
        hex_new  = '0;
        dec_nib  = '0;
        dec_seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dec_nib = bcd_q[4*k +: 4];
            if (ovf_acc_q) begin
                hex_new[7*k +: 7] = SEG_DASH;
            end else if (blank_q && !dec_seen && dec_nib == 4'd0 && k != 0) begin
                hex_new[7*k +: 7] = SEG_BLANK;
            end else begin
                hex_new[7*k +: 7] = seg7(dec_nib);
            end
            if (dec_nib != 4'd0) begin
                dec_seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        ovf_acc_d    = ovf_acc_q;
        blank_d      = blank_q;
        pend_valid_d = pend_valid_q;
        pend_value_d = pend_value_q;
        pend_blank_d = pend_blank_q;
        hex_d        = hex_q;
        overflow_d   = overflow_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (load || pend_valid_q) begin
                    bin_d        = load ? value : pend_value_q;
                    blank_d      = load ? blank_lz : pend_blank_q;
                    bcd_d        = '0;
                    ovf_acc_d    = 1'b0;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d     = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | bcd_adj[BW-1];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                hex_d      = hex_new;
                overflow_d = ovf_acc_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a late request is parked; a newer one replaces it
        if (state_q != IDLE && load) begin
            pend_valid_d = 1'b1;
            pend_value_d = value;
            pend_blank_d = blank_lz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            ovf_acc_q    <= 1'b0;
            blank_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_value_q <= '0;
            pend_blank_q <= 1'b0;
            hex_q        <= {DIGITS{7'b1000000}};
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            ovf_acc_q    <= ovf_acc_d;
            blank_q      <= blank_d;
            pend_valid_q <= pend_valid_d;
            pend_value_q <= pend_value_d;
            pend_blank_q <= pend_blank_d;
            hex_q        <= hex_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign hex      = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// tb/tb_score_bcd_display.sv - randomized and directed checks of score_bcd_display against a decimal model
module tb_score_bcd_display;

    localparam int W = 10;
    localparam int D = 3;
    localparam int LIM = 1000;

    logic           clk = 1'b0;
    logic           reset;
    logic           load;
    logic [W-1:0]   value;
    logic           blank_lz;
    logic           busy;
    logic           done;
    logic           overflow;
    logic [7*D-1:0] hex;

    always #5 clk = ~clk;

    score_bcd_display #(.WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex      (hex)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    // decimal rendering of the score: digits by division, blanking when the value is below 10^k
    function automatic logic [7*D-1:0] exp_hex(input int v, input bit blk);
        logic [7*D-1:0] r;
        int x;
        int p;
        r = '0;
        x = v;
        p = 1;
        for (int k = 0; k < D; k++) begin
            if (v >= LIM)                  r[7*k +: 7] = 7'b0111111;
            else if (blk && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
            else                            r[7*k +: 7] = seg(x % 10);
            x = x / 10;
            p = p * 10;
        end
        return r;
    endfunction

    int             edge_no = 0;
    bit             m_active = 1'b0;
    int             m_start = 0;
    int             m_val = 0;
    bit             m_blk = 1'b0;
    bit             p_valid = 1'b0;
    int             p_val = 0;
    bit             p_blk = 1'b0;
    logic [7*D-1:0] m_hex = {D{7'b1000000}};
    bit             m_ovf = 1'b0;
    bit             m_done = 1'b0;
    bit             m_busy = 1'b0;

    // job timeline: busy for W cycles after the accepting edge, result W+1 edges later
    always @(posedge clk) begin
        edge_no++;
        if (reset) begin
            m_active = 1'b0;
            p_valid  = 1'b0;
            m_hex    = {D{7'b1000000}};
            m_ovf    = 1'b0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (load) begin
                    m_active = 1'b1; m_start = edge_no;
                    m_val = int'(value); m_blk = blank_lz; p_valid = 1'b0;
                end else if (p_valid) begin
                    m_active = 1'b1; m_start = edge_no;
                    m_val = p_val; m_blk = p_blk; p_valid = 1'b0;
                end
            end else begin
                if (load) begin
                    p_valid = 1'b1; p_val = int'(value); p_blk = blank_lz;
                end
                if (edge_no - m_start == W + 1) begin
                    m_hex    = exp_hex(m_val, m_blk);
                    m_ovf    = (m_val >= LIM);
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        m_busy = m_active && (edge_no - m_start) < W;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("hex", 32'(hex), 32'(m_hex));
            if (done) n_done++;
        end
    end

    task automatic do_load(input int v, input bit b);
        @(negedge clk);
        load = 1'b1; value = W'(v); blank_lz = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (done) return;
            @(negedge clk);
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic load_expect(input int v, input bit b, input logic [7*D-1:0] h, input bit o, input string name);
        do_load(v, b);
        wait_done(name);
        check({name, "_hex"}, 32'(hex), 32'(h));
        check({name, "_ovf"}, 32'(overflow), 32'(o));
    endtask

    initial begin
        int c;
        int d0;
        reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_hex", 32'(hex), 32'(21'b1000000_1000000_1000000));
        check("reset_busy", 32'(busy), 32'd0);

        load_expect(0, 1'b0, 21'b1000000_1000000_1000000, 1'b0, "zero");

        do_load(255, 1'b0);
        c = 0;
        while (busy && c < 50) begin c++; @(negedge clk); end
        check("busy_cycles", 32'(c), 32'd10);
        wait_done("v255");
        check("v255_hex", 32'(hex), 32'(21'b0100100_0010010_0010010));

        load_expect(999, 1'b0, 21'b0010000_0010000_0010000, 1'b0, "v999");
        load_expect(1000, 1'b0, 21'b0111111_0111111_0111111, 1'b1, "v1000");
        load_expect(42, 1'b0, 21'b1000000_0011001_0100100, 1'b0, "v42");
        load_expect(7, 1'b1, 21'b1111111_1111111_1111000, 1'b0, "v7_blank");
        load_expect(0, 1'b1, 21'b1111111_1111111_1000000, 1'b0, "v0_blank");

        do_load(123, 1'b0);
        repeat (2) @(negedge clk);
        do_load(456, 1'b0);
        do_load(789, 1'b0);
        d0 = n_done;
        wait_done("q123");
        check("q123_hex", 32'(hex), 32'(21'b1111001_0100100_0110000));
        @(negedge clk);
        wait_done("q789");
        check("q789_hex", 32'(hex), 32'(21'b1111000_0000000_0010000));
        repeat (40) @(negedge clk);
        check("q_done_count", 32'(n_done - d0), 32'd2);

        do_load(500, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        d0 = n_done;
        check("abort_hex", 32'(hex), 32'(21'b1000000_1000000_1000000));
        check("abort_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        load_expect(8, 1'b0, 21'b1000000_1000000_0000000, 1'b0, "v8");

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            load     = ($urandom_range(0, 5) == 0);
            value    = W'($urandom_range(0, (1 << W) - 1));
            blank_lz = 1'(($urandom_range(0, 1)));
            reset    = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        load = 1'b0; reset = 1'b0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
